// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and FSM encoding for the fetch-stage address generator.
// The instruction-address bus width defaults to 32 bits.
package pc_fetch_ctrl_pkg;

    localparam int   INST_ADDR_BUS = 32;

    localparam logic RST_ENABLE    = 1'b0;
    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;

    typedef enum logic [1:0] {
        PC_OFF  = 2'b00,
        PC_RUN  = 2'b01,
        PC_HALT = 2'b10
    } pc_state_e;

endpackage : pc_fetch_ctrl_pkg

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage pc sequencer with stall/back-pressure, buffered branch redirect,
// flush to an exception vector and a halt mode. All outputs are registered.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = INST_ADDR_BUS,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              imem_ready,
    input  logic              halt,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_target,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redirect_pending
);

    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));

    pc_state_e         r_state;
    pc_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_ce;
    logic [ADDR_W-1:0] r_pend;
    logic [ADDR_W-1:0] w_pend_nxt;
    logic              r_pend_vld;
    logic              w_pend_vld_nxt;
    logic              w_advance;
    logic [ADDR_W-1:0] w_branch_aligned;
    logic [ADDR_W-1:0] w_flush_aligned;

    assign w_advance        = r_ce & ~stall & imem_ready;
    assign w_branch_aligned = branch_target & ALIGN_MASK;
    assign w_flush_aligned  = flush_target & ALIGN_MASK;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PC_OFF:  w_state_nxt = halt ? PC_HALT : PC_RUN;
            PC_RUN:  if (halt)  w_state_nxt = PC_HALT;
            PC_HALT: if (!halt) w_state_nxt = PC_RUN;
            default: w_state_nxt = PC_OFF;
        endcase
    end

    // Redirect priority: flush, taken branch, buffered branch, pending replay, sequential.
    always_comb begin
        w_pc_nxt       = r_pc;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        if (r_state != PC_OFF) begin
            if (flush) begin
                w_pc_nxt       = w_flush_aligned;
                w_pend_vld_nxt = 1'b0;
            end else if (branch_flag && w_advance) begin
                w_pc_nxt       = w_branch_aligned;
                w_pend_vld_nxt = 1'b0;
            end else if (branch_flag) begin
                w_pend_nxt     = w_branch_aligned;
                w_pend_vld_nxt = 1'b1;
            end else if (r_pend_vld && w_advance) begin
                w_pc_nxt       = r_pend;
                w_pend_vld_nxt = 1'b0;
            end else if (w_advance) begin
                w_pc_nxt       = r_pc + PC_INC;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state    <= PC_OFF;
            r_pc       <= RESET_VEC;
            r_ce       <= CHIP_DISABLE;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ce       <= (w_state_nxt == PC_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
        end
    end

    assign pc               = r_pc;
    assign ce               = r_ce;
    assign redirect_pending = r_pend_vld;

endmodule : pc_fetch_ctrl

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios then random traffic,
// both compared every cycle against a behavioural model (32-bit and 8-bit instances).
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b1;
    logic        halt = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_target = '0;

    logic [31:0] pc;
    logic        ce;
    logic        redirect_pending;
    logic [7:0]  pc8;
    logic        ce8;
    logic        redirect_pending8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.ADDR_W(32), .INST_BYTES(4), .RESET_VEC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready), .halt(halt),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .flush(flush), .flush_target(flush_target),
        .pc(pc), .ce(ce), .redirect_pending(redirect_pending)
    );

    pc_fetch_ctrl #(.ADDR_W(8), .INST_BYTES(4), .RESET_VEC(8'h0)) u_dut8 (
        .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready), .halt(halt),
        .branch_flag(branch_flag), .branch_target(branch_target[7:0]),
        .flush(flush), .flush_target(flush_target[7:0]),
        .pc(pc8), .ce(ce8), .redirect_pending(redirect_pending8)
    );

    // Behavioural view: "started" means at least one clock edge seen out of reset.
    typedef struct {
        logic [31:0] pc;
        bit          ce;
        logic [31:0] pend;
        bit          pend_vld;
        bit          started;
    } mdl_t;

    mdl_t m32;
    mdl_t m8;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.pc = '0; m.ce = 1'b0; m.pend = '0; m.pend_vld = 1'b0; m.started = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, logic [31:0] mask);
        bit adv;
        adv = m.ce && !stall && imem_ready;
        if (m.started) begin
            if (flush) begin
                m.pc = flush_target & mask & ~32'h3;
                m.pend_vld = 1'b0;
            end else if (branch_flag && adv) begin
                m.pc = branch_target & mask & ~32'h3;
                m.pend_vld = 1'b0;
            end else if (branch_flag) begin
                m.pend = branch_target & mask & ~32'h3;
                m.pend_vld = 1'b1;
            end else if (m.pend_vld && adv) begin
                m.pc = m.pend;
                m.pend_vld = 1'b0;
            end else if (adv) begin
                m.pc = (m.pc + 32'd4) & mask;
            end
        end
        m.started = 1'b1;
        m.ce = !halt;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pc"},  pc,                       m32.pc);
        check({tag, "_ce"},  32'(ce),                  32'(m32.ce));
        check({tag, "_rp"},  32'(redirect_pending),    32'(m32.pend_vld));
        check({tag, "_pc8"}, 32'(pc8),                 m8.pc);
        check({tag, "_ce8"}, 32'(ce8),                 32'(m8.ce));
        check({tag, "_rp8"}, 32'(redirect_pending8),   32'(m8.pend_vld));
    endtask

    task automatic set_in(input bit st, input bit rdy, input bit hl, input bit br,
                          input logic [31:0] bt, input bit fl, input logic [31:0] ft);
        stall = st; imem_ready = rdy; halt = hl;
        branch_flag = br; branch_target = bt; flush = fl; flush_target = ft;
    endtask

    task automatic tick(input string tag);
        if (rst) begin
            m32 = mdl_next(m32, 32'hFFFF_FFFF);
            m8  = mdl_next(m8,  32'h0000_00FF);
        end else begin
            m32 = mdl_reset();
            m8  = mdl_reset();
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        m32 = mdl_reset();
        m8  = mdl_reset();
        set_in(0, 1, 0, 0, '0, 0, '0);

        // Reset state
        @(posedge clk); #1;
        check("rst_ce", 32'(ce), 32'h0);
        check("rst_pc", pc, 32'h0);
        check_model("rst");

        // Release and sequential fetch
        rst = 1'b1;
        tick("seq1"); check("seq1_ce", 32'(ce), 32'h1); check("seq1_pc", pc, 32'h0);
        tick("seq2"); check("seq2_pc", pc, 32'h4);
        tick("seq3"); check("seq3_pc", pc, 32'h8);
        tick("seq4"); check("seq4_pc", pc, 32'hC);
        tick("seq5"); check("seq5_pc", pc, 32'h10);

        // Stall and back-pressure
        set_in(1, 1, 0, 0, '0, 0, '0);
        repeat (3) tick("stall");
        check("stall_pc", pc, 32'h10);
        set_in(0, 0, 0, 0, '0, 0, '0);
        repeat (2) tick("nrdy");
        check("nrdy_pc", pc, 32'h10);
        set_in(0, 1, 0, 0, '0, 0, '0);
        tick("rel"); check("rel_pc", pc, 32'h14);

        // Branch while stalled
        set_in(0, 1, 0, 0, '0, 1, 32'h20);
        tick("fl20"); check("fl20_pc", pc, 32'h20);
        set_in(1, 1, 0, 1, 32'h100, 0, '0);
        tick("brst"); check("brst_pc", pc, 32'h20); check("brst_rp", 32'(redirect_pending), 32'h1);
        set_in(0, 1, 0, 0, '0, 0, '0);
        tick("brrel"); check("brrel_pc", pc, 32'h100); check("brrel_rp", 32'(redirect_pending), 32'h0);
        tick("brnext"); check("brnext_pc", pc, 32'h104);
        set_in(1, 1, 0, 1, 32'h1F0, 0, '0);
        tick("br2a");
        set_in(1, 1, 0, 1, 32'h200, 0, '0);
        tick("br2b"); check("br2b_rp", 32'(redirect_pending), 32'h1);
        set_in(0, 1, 0, 0, '0, 0, '0);
        tick("br2rel"); check("br2rel_pc", pc, 32'h200);

        // Flush beats branch and pending redirect
        set_in(1, 1, 0, 1, 32'h240, 0, '0);
        tick("pend");
        set_in(0, 1, 0, 1, 32'h300, 1, 32'h180);
        tick("flpri"); check("flpri_pc", pc, 32'h180); check("flpri_rp", 32'(redirect_pending), 32'h0);

        // Flush during halt
        set_in(0, 1, 1, 0, '0, 0, '0);
        tick("hlt");
        set_in(0, 1, 1, 0, '0, 1, 32'h180);
        tick("hltfl"); check("hltfl_pc", pc, 32'h180); check("hltfl_ce", 32'(ce), 32'h0);

        // Halt parks at 0x40
        set_in(0, 1, 0, 0, '0, 1, 32'h40);
        tick("to40"); check("to40_pc", pc, 32'h40);
        set_in(1, 1, 1, 0, '0, 0, '0);
        tick("park1");
        set_in(0, 1, 1, 0, '0, 0, '0);
        tick("park2"); check("park_pc", pc, 32'h40); check("park_ce", 32'(ce), 32'h0);
        set_in(0, 1, 0, 0, '0, 0, '0);
        tick("unpark"); check("unpark_ce", 32'(ce), 32'h1); check("unpark_pc", pc, 32'h40);
        tick("unpark2"); check("unpark2_pc", pc, 32'h44);

        // Target alignment
        set_in(0, 1, 0, 1, 32'h103, 0, '0);
        tick("align"); check("align_pc", pc, 32'h100);

        // Wrap on both widths
        set_in(0, 1, 0, 0, '0, 1, 32'hFFFF_FFFC);
        tick("wrapa"); check("wrapa_pc8", 32'(pc8), 32'hFC);
        set_in(0, 1, 0, 0, '0, 0, '0);
        tick("wrapb"); check("wrapb_pc", pc, 32'h0); check("wrapb_pc8", 32'(pc8), 32'h0);

        // Asynchronous reset between edges with a pending redirect
        set_in(1, 1, 0, 1, 32'h500, 0, '0);
        tick("apend"); check("apend_rp", 32'(redirect_pending), 32'h1);
        set_in(1, 1, 0, 0, '0, 0, '0);
        #2;
        rst = 1'b0;
        #1;
        m32 = mdl_reset();
        m8  = mdl_reset();
        check("arst_ce", 32'(ce), 32'h0);
        check("arst_pc", pc, 32'h0);
        check("arst_rp", 32'(redirect_pending), 32'h0);
        tick("arst_hold");

        // Release straight into halt, then run
        set_in(0, 1, 1, 0, '0, 0, '0);
        rst = 1'b1;
        tick("offhalt"); check("offhalt_ce", 32'(ce), 32'h0);
        set_in(0, 1, 0, 0, '0, 0, '0);
        tick("offrun"); check("offrun_pc", pc, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(3) == 0), ($urandom_range(3) != 0), ($urandom_range(9) == 0),
                   ($urandom_range(4) == 0), $urandom(), ($urandom_range(15) == 0), $urandom());
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_fetch_ctrl
